nm_port_arbiter: RTL and testbench
==================================

Name: nm_port_arbiter

Overview:
Shares the single neuron_module access port among NUM_REQ requesters. Requester 0 is the host write FIFO, requester 1 the activity readout scanner, and requester 2 spare. Arbitration is round-robin, and a grant is held until neuron_module acknowledges the access. A watchdog aborts accesses that never receive an ack. The block sits between the system control/readout logic and neuron_module.

Parameters:
NEURON_NUMBER, 256, neuron count; address width AW = $clog2(NEURON_NUMBER)
NEUR_WIDTH, 13, bits per neuron word (ACTIVITY_WIDTH + REFRACTORY_WIDTH)
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT, 64, cycles in BUSY without nm_ack before abort (>= 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  1  arbitration enable (driven from sys_en); 0 blocks new grants
req_i  in  NUM_REQ  per-requester request level
addr_i  in  NUM_REQ*AW  flattened addresses; slice k = requester k
data_i  in  NUM_REQ*NEUR_WIDTH  flattened write data
we_i  in  NUM_REQ  per-requester write enable
ack_o  out  NUM_REQ  one-hot, 1-cycle completion pulse
rdata_o  out  NEUR_WIDTH  read data; valid while any ack_o bit is high
grant_o  out  NUM_REQ  one-hot current grant; 0 when idle
nm_req  out  1  request to neuron_module (registered)
nm_addr  out  AW  registered address
nm_data  out  NEUR_WIDTH  registered write data
nm_we  out  1  registered write enable
nm_ack  in  1  1-cycle accept pulse from neuron_module
nm_rdata  in  NEUR_WIDTH  read data, valid with nm_ack
timeout_err  out  1  sticky abort flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset values: state IDLE, rr_ptr=0, grant_o=0, nm_req=0, nm_addr=0, nm_data=0, nm_we=0, timeout_err=0, wdog=0.
- ack_o = grant_o & {NUM_REQ{nm_ack}}, combinational, so a FIFO can pop on the same cycle. rdata_o = nm_rdata, passed through.
- Requester protocol:
  - hold req_i, addr, data and we stable until its ack_o pulse;
  - the arbiter samples these only at the grant edge;
  - deasserting req while granted is a protocol violation and is ignored: the access completes and the ack pulse is still issued.
- IDLE:
  - when en=1 and req_i!=0, pick the first set bit scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ;
  - at that edge register grant_o (one-hot), nm_addr, nm_data and nm_we from the winner's slices, set nm_req=1, clear wdog, go to BUSY;
  - request-to-nm_req latency is 1 cycle.
- BUSY:
  - nm_req and all latched fields are held; req_i is ignored.
  - On nm_ack: the granted ack_o bit pulses that cycle. At the edge: nm_req=0, nm_we=0, grant_o=0, rr_ptr=(granted index+1) mod NUM_REQ, go to IDLE.
  - nm_req is therefore low for at least 1 cycle between accesses. Maximum throughput is 1 access per 2 cycles when neuron_module acks in the first request cycle.
  - Without nm_ack, wdog increments. When wdog==TIMEOUT-1 and nm_ack=0: abort. nm_req=0, grant_o=0, no ack_o pulse, timeout_err=1, rr_ptr advances past the aborted requester, go to IDLE. The requester may retry.
  - If nm_ack arrives on the same cycle the timeout would fire, the ack wins: normal completion, no error.
- nm_ack while IDLE (stray ack): ignored, no ack_o pulse.
- en drops during BUSY: the in-flight access completes or times out normally; no new grant while en=0.
- timeout_err: set has priority over err_clr on the same cycle.
- Reset mid-access: all registers return to reset values at the reset edge and no ack_o is issued. Requesters must re-request.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,0,... No requester waits more than NUM_REQ-1 accesses.

Decomposition:
- Shared package nm_pkg holds:
  - NEUR_WIDTH derivation and AW helper;
  - typedef enum logic {IDLE_S, BUSY_S} arb_state_t;
  - requester index constants REQ_HOST=0, REQ_SCAN=1, REQ_SPARE=2.
- One sub-module, nm_rr_picker: combinational rotate-priority-rotate-back picker (inputs req vector and rr_ptr, outputs one-hot winner and valid). Reusable for later spike-bus arbitration.

Test Plan:
- Single write: req_i=001, addr0=8'h12, data0=13'h0AB0, we=1, nm_ack 3 cycles after nm_req -> nm_req high 1 cycle after req, nm_addr=8'h12, nm_we=1, ack_o=001 coincident with nm_ack, grant_o returns to 0.
- Contention: req_i=111 held, nm_ack returned on the 1st nm_req cycle each time -> grant sequence 001,010,100,001, one access per 2 cycles, each ack_o pulse exactly 1 cycle.
- Read path: requester 1, we=0, nm_rdata=13'h1F3 with nm_ack -> rdata_o=13'h1F3 and ack_o=010 on the same cycle.
- Timeout: requester 0 granted, nm_ack withheld, TIMEOUT=64 -> nm_req drops after 64 BUSY cycles, no ack_o, timeout_err=1; err_clr pulse clears it; next grant goes to requester 1 if it is requesting.
- en gating and stray ack: en=0 with req_i=010 -> no nm_req; nm_ack pulsed while idle -> ack_o stays 0; en=1 -> grant 1 cycle later.
- Reset mid-access: reset asserted in BUSY with nm_ack arriving on the same cycle -> next cycle nm_req=0, grant_o=0, rr_ptr=0, timeout_err=0; subsequent req_i=100 is granted normally.

Source files
------------

// File: rtl/nm_pkg.sv
// Shared types and constants for the neuron_module access path.
// Also holds the helpers that size addresses and neuron words.
package nm_pkg;

  localparam int ACTIVITY_WIDTH   = 9;
  localparam int REFRACTORY_WIDTH = 4;
  localparam int NM_NEUR_WIDTH    = ACTIVITY_WIDTH + REFRACTORY_WIDTH;

  localparam int REQ_HOST  = 0;
  localparam int REQ_SCAN  = 1;
  localparam int REQ_SPARE = 2;

  typedef enum logic {IDLE_S = 1'b0, BUSY_S = 1'b1} arb_state_t;

  function automatic int nm_addr_width(input int neuron_number);
    return (neuron_number > 1) ? $clog2(neuron_number) : 1;
  endfunction

endpackage

// File: rtl/nm_rr_picker.sv
// Round-robin picker: rotate the request vector so ptr sits at bit 0,
// take the lowest set bit, then rotate the one-hot result back.
module nm_rr_picker #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  logic [N-1:0] rot;
  logic [N-1:0] first;
  int           idx;

  always_comb begin
    rot    = '0;
    first  = '0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      rot[i] = req[idx];
    end
    first = rot & (~rot + 1'b1);
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      winner[idx] = first[i];
    end
    valid = |req;
  end

endmodule

// File: rtl/nm_port_arbiter.sv
// Round-robin arbiter sharing the single neuron_module port among NUM_REQ
// requesters, with a grant held until nm_ack and a watchdog abort.
module nm_port_arbiter
  import nm_pkg::*;
#(
  parameter int NEURON_NUMBER = 256,
  parameter int NEUR_WIDTH    = NM_NEUR_WIDTH,
  parameter int NUM_REQ       = 3,
  parameter int TIMEOUT       = 64,
  localparam int AW = nm_addr_width(NEURON_NUMBER),
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*AW-1:0]         addr_i,
  input  logic [NUM_REQ*NEUR_WIDTH-1:0] data_i,
  input  logic [NUM_REQ-1:0]            we_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [NEUR_WIDTH-1:0]         rdata_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          nm_req,
  output logic [AW-1:0]                 nm_addr,
  output logic [NEUR_WIDTH-1:0]         nm_data,
  output logic                          nm_we,
  input  logic                          nm_ack,
  input  logic [NEUR_WIDTH-1:0]         nm_rdata,
  output logic                          timeout_err,
  input  logic                          err_clr,
  output arb_state_t                    dbg_state,
  output logic [PW-1:0]                 dbg_rr_ptr
);

  localparam int WW = $clog2(TIMEOUT);

  // Handshake: a requester holds req/addr/data/we until its ack_o pulse;
  // fields are sampled only at the grant edge. nm_req is the valid toward
  // neuron_module and stays high until a 1-cycle nm_ack (ready) or abort.
  arb_state_t         state;
  logic [PW-1:0]      rr_ptr;
  logic [WW-1:0]      wdog;
  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic [AW-1:0]         win_addr;
  logic [NEUR_WIDTH-1:0] win_data;
  logic                  win_we;
  logic [PW-1:0]         grant_idx;
  logic [PW-1:0]         next_ptr;
  logic                  wdog_expired;

  nm_rr_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
    .req    (req_i),
    .ptr    (rr_ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_comb begin
    win_addr  = '0;
    win_data  = '0;
    win_we    = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) begin
        win_addr = addr_i[k*AW +: AW];
        win_data = data_i[k*NEUR_WIDTH +: NEUR_WIDTH];
        win_we   = we_i[k];
      end
      if (grant_o[k]) grant_idx = PW'(k);
    end
    next_ptr     = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    wdog_expired = (state == BUSY_S) && !nm_ack && (wdog == WW'(TIMEOUT - 1));
  end

  // Reset wins over a coincident nm_ack, so no completion is reported.
  assign ack_o      = grant_o & {NUM_REQ{nm_ack & ~reset}};
  assign rdata_o    = nm_rdata;
  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE_S;
      rr_ptr  <= '0;
      wdog    <= '0;
      grant_o <= '0;
      nm_req  <= 1'b0;
      nm_addr <= '0;
      nm_data <= '0;
      nm_we   <= 1'b0;
    end else begin
      case (state)
        IDLE_S: begin
          if (en && pick_valid) begin
            grant_o <= pick;
            nm_addr <= win_addr;
            nm_data <= win_data;
            nm_we   <= win_we;
            nm_req  <= 1'b1;
            wdog    <= '0;
            state   <= BUSY_S;
          end
        end
        BUSY_S: begin
          if (nm_ack || wdog_expired) begin
            nm_req  <= 1'b0;
            nm_we   <= 1'b0;
            grant_o <= '0;
            rr_ptr  <= next_ptr;
            state   <= IDLE_S;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE_S;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)             timeout_err <= 1'b0;
    else if (wdog_expired) timeout_err <= 1'b1;
    else if (err_clr)      timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_nm_port_arbiter.sv
// Directed bench for nm_port_arbiter: cycle table for grant/ack behaviour,
// plus hand sequences for timeout, ack-vs-timeout race and reset mid-access.
module tb_nm_port_arbiter;
  import nm_pkg::*;

  localparam int NR = 3;
  localparam int AW = 8;
  localparam int NW = 13;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic [NR-1:0]  req_i;
  logic [NR*AW-1:0] addr_i;
  logic [NR*NW-1:0] data_i;
  logic [NR-1:0]  we_i;
  logic [NR-1:0]  ack_o;
  logic [NW-1:0]  rdata_o;
  logic [NR-1:0]  grant_o;
  logic           nm_req;
  logic [AW-1:0]  nm_addr;
  logic [NW-1:0]  nm_data;
  logic           nm_we;
  logic           nm_ack;
  logic [NW-1:0]  nm_rdata;
  logic           timeout_err;
  logic           err_clr;
  arb_state_t     dbg_state;
  logic [1:0]     dbg_rr_ptr;

  int tests = 0;
  int fails = 0;

  nm_port_arbiter #(
    .NEURON_NUMBER(256), .NEUR_WIDTH(NW), .NUM_REQ(NR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .req_i(req_i), .addr_i(addr_i),
    .data_i(data_i), .we_i(we_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .grant_o(grant_o), .nm_req(nm_req), .nm_addr(nm_addr), .nm_data(nm_data),
    .nm_we(nm_we), .nm_ack(nm_ack), .nm_rdata(nm_rdata),
    .timeout_err(timeout_err), .err_clr(err_clr),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // clock / global time bound
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "time limit");
  end

  typedef struct {
    logic          en;
    logic [NR-1:0] req;
    logic          ack;
    logic [NW-1:0] rdata;
    logic [NR-1:0] exp_grant;
    logic          exp_nm_req;
    logic [NR-1:0] exp_ack;
    logic [AW-1:0] exp_addr;
    logic [NW-1:0] exp_data;
    logic          exp_we;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic e, input logic [NR-1:0] r, input logic a,
                         input logic [NW-1:0] rd, input logic [NR-1:0] g,
                         input logic nr, input logic [NR-1:0] ak,
                         input logic [AW-1:0] ad, input logic [NW-1:0] dt,
                         input logic w);
    vec_t v;
    v.en = e; v.req = r; v.ack = a; v.rdata = rd; v.exp_grant = g;
    v.exp_nm_req = nr; v.exp_ack = ak; v.exp_addr = ad; v.exp_data = dt;
    v.exp_we = w;
    vecs.push_back(v);
  endtask

  initial begin
    int cnt;
    int acks_seen;

    // contention from rr_ptr=0, ack on first nm_req cycle; requester 1 reads
    add_vec(1, 3'b111, 0, 13'h000, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);
    add_vec(1, 3'b111, 1, 13'h000, 3'b001, 1, 3'b001, 8'h12, 13'h0AB0, 1);
    add_vec(1, 3'b111, 0, 13'h000, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);
    add_vec(1, 3'b111, 1, 13'h1F3, 3'b010, 1, 3'b010, 8'h34, 13'h0555, 0);
    add_vec(1, 3'b111, 0, 13'h000, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);
    add_vec(1, 3'b111, 1, 13'h000, 3'b100, 1, 3'b100, 8'h56, 13'h1234, 1);
    add_vec(1, 3'b111, 0, 13'h000, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);
    add_vec(1, 3'b111, 1, 13'h000, 3'b001, 1, 3'b001, 8'h12, 13'h0AB0, 1);
    add_vec(1, 3'b000, 0, 13'h000, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);
    // single write, ack 3 cycles after nm_req rises
    add_vec(1, 3'b001, 0, 13'h000, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);
    add_vec(1, 3'b001, 0, 13'h000, 3'b001, 1, 3'b000, 8'h12, 13'h0AB0, 1);
    add_vec(1, 3'b001, 0, 13'h000, 3'b001, 1, 3'b000, 8'h12, 13'h0AB0, 1);
    add_vec(1, 3'b001, 0, 13'h000, 3'b001, 1, 3'b000, 8'h12, 13'h0AB0, 1);
    add_vec(1, 3'b001, 1, 13'h000, 3'b001, 1, 3'b001, 8'h12, 13'h0AB0, 1);
    add_vec(1, 3'b000, 0, 13'h000, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);
    // en gating, stray ack, en dropping while busy
    add_vec(0, 3'b010, 0, 13'h000, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);
    add_vec(0, 3'b010, 1, 13'h0AA, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);
    add_vec(0, 3'b010, 0, 13'h000, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);
    add_vec(1, 3'b010, 0, 13'h000, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);
    add_vec(0, 3'b010, 1, 13'h0C3, 3'b010, 1, 3'b010, 8'h34, 13'h0555, 0);
    add_vec(0, 3'b010, 0, 13'h000, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);
    add_vec(0, 3'b000, 0, 13'h000, 3'b000, 0, 3'b000, 8'h00, 13'h0000, 0);

    reset = 1'b1; en = 1'b1; req_i = '0; nm_ack = 1'b0; nm_rdata = '0;
    err_clr = 1'b0;
    addr_i = {8'h56, 8'h34, 8'h12};
    data_i = {13'h1234, 13'h0555, 13'h0AB0};
    we_i   = 3'b101;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_state", dbg_state, IDLE_S);
    chk("rst_rr_ptr", dbg_rr_ptr, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_nm_req", nm_req, 0);
    chk("rst_nm_addr", nm_addr, 0);
    chk("rst_nm_data", nm_data, 0);
    chk("rst_nm_we", nm_we, 0);
    chk("rst_timeout_err", timeout_err, 0);

    foreach (vecs[i]) begin
      en = vecs[i].en; req_i = vecs[i].req;
      nm_ack = vecs[i].ack; nm_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_grant", i), grant_o, vecs[i].exp_grant);
      chk($sformatf("v%0d_nm_req", i), nm_req, vecs[i].exp_nm_req);
      chk($sformatf("v%0d_ack", i), ack_o, vecs[i].exp_ack);
      if (vecs[i].exp_nm_req) begin
        chk($sformatf("v%0d_nm_addr", i), nm_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d_nm_data", i), nm_data, vecs[i].exp_data);
        chk($sformatf("v%0d_nm_we", i), nm_we, vecs[i].exp_we);
      end
      if (vecs[i].exp_ack != 0) chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].rdata);
      tick();
    end

    // timeout: requester 0 granted (rr_ptr=2), ack withheld
    en = 1'b1; req_i = 3'b011; nm_ack = 1'b0;
    tick();
    chk("to_grant", grant_o, 3'b001);
    chk("to_nm_addr", nm_addr, 8'h12);
    cnt = 0; acks_seen = 0;
    while (nm_req && cnt < 200) begin
      if (ack_o != 0) acks_seen++;
      cnt++;
      tick();
    end
    chk("to_busy_cycles", cnt, TO);
    chk("to_no_ack", acks_seen, 0);
    chk("to_err_set", timeout_err, 1);
    chk("to_grant_clr", grant_o, 0);
    tick();
    chk("to_next_grant", grant_o, 3'b010);
    chk("to_err_sticky", timeout_err, 1);
    err_clr = 1'b1; nm_ack = 1'b1;
    #1;
    chk("to_retry_ack", ack_o, 3'b010);
    tick();
    err_clr = 1'b0; nm_ack = 1'b0; req_i = '0;
    chk("to_err_clr", timeout_err, 0);
    chk("to_done_grant", grant_o, 0);

    // ack on the cycle the watchdog would fire: ack wins
    req_i = 3'b100;
    tick();
    chk("race_grant", grant_o, 3'b100);
    cnt = 0;
    for (int k = 0; k < TO - 1; k++) begin
      tick();
      if (nm_req) cnt++;
    end
    chk("race_req_held", cnt, TO - 1);
    nm_ack = 1'b1;
    #1;
    chk("race_ack", ack_o, 3'b100);
    tick();
    nm_ack = 1'b0; req_i = '0;
    chk("race_no_err", timeout_err, 0);
    chk("race_grant_clr", grant_o, 0);
    chk("race_nm_req", nm_req, 0);

    // reset mid-access with a coincident nm_ack
    req_i = 3'b001;
    tick();
    nm_ack = 1'b1;
    tick();
    nm_ack = 1'b0; req_i = 3'b010;
    tick();
    chk("rm_grant", grant_o, 3'b010);
    chk("rm_rr_ptr", dbg_rr_ptr, 1);
    reset = 1'b1; nm_ack = 1'b1;
    #1;
    chk("rm_no_ack", ack_o, 0);
    tick();
    reset = 1'b0; nm_ack = 1'b0; req_i = '0;
    #1;
    chk("rm_nm_req", nm_req, 0);
    chk("rm_grant_clr", grant_o, 0);
    chk("rm_rr_ptr0", dbg_rr_ptr, 0);
    chk("rm_state", dbg_state, IDLE_S);
    chk("rm_timeout_err", timeout_err, 0);
    req_i = 3'b100;
    tick();
    chk("rm_regrant", grant_o, 3'b100);
    chk("rm_regrant_req", nm_req, 1);
    chk("rm_regrant_addr", nm_addr, 8'h56);
    nm_ack = 1'b1;
    #1;
    chk("rm_regrant_ack", ack_o, 3'b100);
    tick();
    nm_ack = 1'b0; req_i = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
